ascon_host_ctrl: RTL
====================

Name: ascon_host_ctrl

Overview:
Host-side sequencer that drives the ascon_top encryption core through one complete AEAD message. The message is one associated-data block A1 and three plaintext blocks P1..P3. On a single go_i pulse it latches key, nonce and blocks, then issues start and the four data_valid pulses, each gated by the core's end_* handshakes. It collects the three ciphertext blocks and the tag, and a watchdog flags a core that stalls.

Parameters:
TIMEOUT_CYCLES, 256, maximum cycles spent in any WAIT_* state before the block aborts to ERROR.
NB_PT, 3, plaintext block count; fixed to 3 in this revision, and other values are unsupported.

Ports:
clock_i  in  1  system clock
resetb_i  in  1  synchronous active-low reset
go_i  in  1  one-cycle request to encrypt one message
key_i  in  128  key, latched on accepted go_i
nonce_i  in  128  nonce, latched on accepted go_i
ad_i  in  128  A1, already padded and word-ordered by software
pt_i  in  384  P1=[127:0], P2=[255:128], P3=[383:256]; P3 is already padded
start_o  out  1  to core start_i
key_o  out  128  to core key_i, held stable from latch
nonce_o  out  128  to core nonce_i, held stable from latch
data_o  out  128  to core data_i
data_valid_o  out  1  to core data_valid_i
cipher_valid_i  in  1  from core
cipher_i  in  128  from core
end_initialisation_i, end_associate_i, end_cipher1_i, end_cipher2_i, end_i  in  1 each  core phase-end pulses
tag_i  in  128  from core
ct_o  out  384  captured ciphertext; C1=[127:0], C2=[255:128], C3=[383:256]
tag_o  out  128  captured tag
busy_o  out  1  high from accepted go_i until DONE/ERROR
done_o  out  1  one-cycle pulse on successful completion
timeout_o  out  1  sticky error flag, cleared on next accepted go_i
extra_ct_o  out  1  sticky flag: cipher_valid_i seen more than 3 times

Behaviour:
- Reset (resetb_i low at a clock edge): state goes to IDLE.
  - All outputs go to 0, including ct_o and tag_o.
  - Counters go to 0.
  - Reset asserted mid-message aborts immediately; no done_o is issued.
- FSM states: IDLE, START, WAIT_INIT, SEND_AD, WAIT_AD, SEND_P1, WAIT_P1, SEND_P2, WAIT_P2, SEND_P3, WAIT_END, DONE, ERROR.
- IDLE, go_i=1:
  - Latch key, nonce, ad and pt.
  - Clear ct_o, tag_o, timeout_o, extra_ct_o and the ct counter.
  - Go to START. busy_o=1 from the next cycle.
- go_i while busy_o=1: ignored, with no effect.
- START: start_o=1 for exactly this cycle, then go to WAIT_INIT.
- SEND_x: data_o loads the block and data_valid_o=1 for exactly one cycle, then go to the matching WAIT_x.
  - data_o keeps its value until the next SEND_x.
- Transitions on phase-end pulses:
  - WAIT_INIT goes to SEND_AD on end_initialisation_i.
  - WAIT_AD goes to SEND_P1 on end_associate_i.
  - WAIT_P1 goes to SEND_P2 on end_cipher1_i.
  - WAIT_P2 goes to SEND_P3 on end_cipher2_i.
  - WAIT_END: on end_i, tag_o<=tag_i, then go to DONE.
  - end_* pulses that do not belong to the current WAIT state are ignored.
- DONE: done_o=1 for one cycle and busy_o drops in the same cycle, then go to IDLE.
  - ct_o and tag_o hold until the next accepted go_i.
- Ciphertext capture runs in every non-IDLE state.
  - On cipher_valid_i, slot ct_cnt (0..2) gets cipher_i and ct_cnt increments.
  - At ct_cnt=3 the data is discarded and extra_ct_o<=1.
  - cipher_valid_i in the same cycle as an end_* pulse: both are processed.
- Watchdog:
  - The counter clears on entry to every WAIT_* state and increments each cycle spent in it.
  - At TIMEOUT_CYCLES-1 with no expected pulse, go to ERROR with timeout_o<=1.
  - Expected pulse and terminal count in the same cycle: the pulse wins.
- ERROR: busy_o=0 for one cycle, then IDLE. timeout_o stays set; done_o is not pulsed.
- No data reordering or padding is done here; blocks pass bit-exact.

Decomposition:
- ascon_pack gains:
  - the host_state_t enum;
  - the HOST_TIMEOUT_DEFAULT constant;
  - a typedef for the 3x128 block array.
- One sub-module, ascon_watchdog: a loadable down/up counter with clear, enable and terminal-count output.
- ct capture and the FSM stay in the top-level module.

Test Plan:
1. Nominal run against a behavioural core model.
   - Model: each end_* 12 cycles after its trigger; cipher_o=data_i^{128{1'b1}} on cipher_valid 2 cycles after each P data_valid; tag_o=128'hA5A5...A5.
   - Stimulus: key 691AED630E81901F6CB10AD9CA912F80, nonce 46487B3E06D9D7A80C4C36A20853217C, A1 6F74206563696C4100000001626F4220, P1 7475657620657551704F206572696420, P2 74614E2061747265766E492065617275, P3 4D20746E75696E65013F206172656E75.
   - Required: ct_o slots are the bitwise inverse of P1..P3, tag_o=A5..A5, done_o is a single pulse, and exactly 1 start_o and 4 data_valid_o pulses occur in order.
2. Model withholds end_cipher1 -> timeout_o=1 exactly TIMEOUT_CYCLES cycles after WAIT_P1 entry, no done_o, IDLE next; a new go_i clears timeout_o.
3. go_i repeated during WAIT_AD -> no second start_o; the first message completes unchanged.
4. resetb_i=0 for one cycle in WAIT_P2 -> all outputs 0 next cycle; a subsequent go_i runs a clean full message.
5. Model emits 4 cipher_valid pulses -> C1..C3 are from the first three pulses and extra_ct_o=1.
6. Model asserts end_associate during WAIT_INIT, then end_initialisation -> the stray pulse is ignored and the A1 data_valid follows end_initialisation only.

Source files
------------

// File: rtl/ascon_pack.sv
// Shared types and constants for the Ascon host-side sequencer.
package ascon_pack;

    localparam int HOST_TIMEOUT_DEFAULT = 256;
    localparam int HOST_NB_PT           = 3;

    typedef enum logic [3:0] {
        IDLE      = 4'd0,
        START     = 4'd1,
        WAIT_INIT = 4'd2,
        SEND_AD   = 4'd3,
        WAIT_AD   = 4'd4,
        SEND_P1   = 4'd5,
        WAIT_P1   = 4'd6,
        SEND_P2   = 4'd7,
        WAIT_P2   = 4'd8,
        SEND_P3   = 4'd9,
        WAIT_END  = 4'd10,
        DONE      = 4'd11,
        ERROR     = 4'd12
    } host_state_t;

    typedef logic [HOST_NB_PT-1:0][127:0] host_blk3_t;

    function automatic logic is_wait_state(input host_state_t s);
        case (s)
            WAIT_INIT, WAIT_AD, WAIT_P1, WAIT_P2, WAIT_END: is_wait_state = 1'b1;
            default:                                        is_wait_state = 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/ascon_watchdog.sv
// Loadable up/down counter with clear, enable and a registered terminal-count flag.
module ascon_watchdog #(
    parameter int W = 9
) (
    input  logic         clock_i,
    input  logic         resetb_i,
    input  logic         clr_i,
    input  logic         load_i,
    input  logic [W-1:0] load_val_i,
    input  logic         en_i,
    input  logic         up_i,
    input  logic [W-1:0] tc_val_i,
    output logic         tc_o
);

    localparam logic [W-1:0] ONE = {{(W-1){1'b0}}, 1'b1};

    logic [W-1:0] cnt_r;
    logic [W-1:0] cnt_nxt_s;
    logic         tc_r;

    // Next count: clear has priority over load, load over counting.
    always_comb begin
        cnt_nxt_s = cnt_r;
        if (clr_i) begin
            cnt_nxt_s = {W{1'b0}};
        end else if (load_i) begin
            cnt_nxt_s = load_val_i;
        end else if (en_i) begin
            if (up_i) begin
                cnt_nxt_s = cnt_r + ONE;
            end else begin
                cnt_nxt_s = cnt_r - ONE;
            end
        end else begin
            cnt_nxt_s = cnt_r;
        end
    end

    // Count register; tc is registered from the next count so it tracks cnt_r exactly.
    always_ff @(posedge clock_i) begin
        if (!resetb_i) begin
            cnt_r <= {W{1'b0}};
            tc_r  <= 1'b0;
        end else begin
            cnt_r <= cnt_nxt_s;
            tc_r  <= (cnt_nxt_s == tc_val_i);
        end
    end

    assign tc_o = tc_r;

endmodule

// File: rtl/ascon_host_ctrl.sv
// Host sequencer: feeds one AD block and three plaintext blocks to the Ascon core,
// collects ciphertext and tag, and aborts on a stalled core.
module ascon_host_ctrl
    import ascon_pack::*;
#(
    parameter int TIMEOUT_CYCLES = HOST_TIMEOUT_DEFAULT,
    parameter int NB_PT          = HOST_NB_PT
) (
    input  logic         clock_i,
    input  logic         resetb_i,
    input  logic         go_i,
    input  logic [127:0] key_i,
    input  logic [127:0] nonce_i,
    input  logic [127:0] ad_i,
    input  logic [383:0] pt_i,
    output logic         start_o,
    output logic [127:0] key_o,
    output logic [127:0] nonce_o,
    output logic [127:0] data_o,
    output logic         data_valid_o,
    input  logic         cipher_valid_i,
    input  logic [127:0] cipher_i,
    input  logic         end_initialisation_i,
    input  logic         end_associate_i,
    input  logic         end_cipher1_i,
    input  logic         end_cipher2_i,
    input  logic         end_i,
    input  logic [127:0] tag_i,
    output logic [383:0] ct_o,
    output logic [127:0] tag_o,
    output logic         busy_o,
    output logic         done_o,
    output logic         timeout_o,
    output logic         extra_ct_o
);

    localparam int              WD_W  = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [WD_W-1:0] WD_TC = WD_W'(TIMEOUT_CYCLES - 1);

    host_state_t  state_r, next_state_s;
    logic         exp_pulse_s, wd_clr_s, wd_en_s, wd_tc_s, go_acc_s;
    logic         start_s, dv_s, busy_s, done_s;
    logic [127:0] data_s;
    logic         start_r, dv_r, busy_r, done_r, timeout_r, extra_r;
    logic [127:0] data_r, key_r, nonce_r, ad_r, tag_r;
    host_blk3_t   pt_r, ct_r;
    logic [1:0]   ct_cnt_r;

    assign go_acc_s = (state_r == IDLE) && go_i;
    assign wd_clr_s = is_wait_state(next_state_s) && (next_state_s != state_r);
    assign wd_en_s  = is_wait_state(state_r);

    ascon_watchdog #(.W(WD_W)) u_watchdog (
        .clock_i    (clock_i),
        .resetb_i   (resetb_i),
        .clr_i      (wd_clr_s),
        .load_i     (1'b0),
        .load_val_i ({WD_W{1'b0}}),
        .en_i       (wd_en_s),
        .up_i       (1'b1),
        .tc_val_i   (WD_TC),
        .tc_o       (wd_tc_s)
    );

    // State register.
    always_ff @(posedge clock_i) begin
        if (!resetb_i) begin
            state_r <= IDLE;
        end else begin
            state_r <= next_state_s;
        end
    end

    // Next state; in a WAIT state the expected pulse beats the watchdog.
    always_comb begin
        next_state_s = state_r;
        exp_pulse_s  = 1'b0;
        case (state_r)
            IDLE:      next_state_s = go_i ? START : IDLE;
            START:     next_state_s = WAIT_INIT;
            WAIT_INIT: exp_pulse_s  = end_initialisation_i;
            SEND_AD:   next_state_s = WAIT_AD;
            WAIT_AD:   exp_pulse_s  = end_associate_i;
            SEND_P1:   next_state_s = WAIT_P1;
            WAIT_P1:   exp_pulse_s  = end_cipher1_i;
            SEND_P2:   next_state_s = WAIT_P2;
            WAIT_P2:   exp_pulse_s  = end_cipher2_i;
            SEND_P3:   next_state_s = WAIT_END;
            WAIT_END:  exp_pulse_s  = end_i;
            DONE:      next_state_s = IDLE;
            ERROR:     next_state_s = IDLE;
            default:   next_state_s = IDLE;
        endcase
        if (is_wait_state(state_r)) begin
            if (exp_pulse_s) begin
                next_state_s = host_state_t'(state_r + 4'd1);
            end else if (wd_tc_s) begin
                next_state_s = ERROR;
            end else begin
                next_state_s = state_r;
            end
        end else begin
            next_state_s = next_state_s;
        end
    end

    // Outputs decoded from the next state so the registered copies align with the state.
    always_comb begin
        start_s = (next_state_s == START);
        busy_s  = (next_state_s != IDLE) && (next_state_s != DONE) && (next_state_s != ERROR);
        done_s  = (next_state_s == DONE);
        dv_s    = 1'b1;
        data_s  = data_r;
        case (next_state_s)
            SEND_AD: data_s = ad_r;
            SEND_P1: data_s = pt_r[0];
            SEND_P2: data_s = pt_r[1];
            SEND_P3: data_s = pt_r[2];
            default: begin
                dv_s   = 1'b0;
                data_s = data_r;
            end
        endcase
    end

    // Registered control outputs and data bus.
    always_ff @(posedge clock_i) begin
        if (!resetb_i) begin
            start_r <= 1'b0;
            dv_r    <= 1'b0;
            busy_r  <= 1'b0;
            done_r  <= 1'b0;
            data_r  <= 128'd0;
        end else begin
            start_r <= start_s;
            dv_r    <= dv_s;
            busy_r  <= busy_s;
            done_r  <= done_s;
            data_r  <= data_s;
        end
    end

    // Message latch, ciphertext/tag capture and sticky flags.
    always_ff @(posedge clock_i) begin
        if (!resetb_i) begin
            key_r     <= 128'd0;
            nonce_r   <= 128'd0;
            ad_r      <= 128'd0;
            pt_r      <= 384'd0;
            ct_r      <= 384'd0;
            tag_r     <= 128'd0;
            ct_cnt_r  <= 2'd0;
            timeout_r <= 1'b0;
            extra_r   <= 1'b0;
        end else if (go_acc_s) begin
            key_r     <= key_i;
            nonce_r   <= nonce_i;
            ad_r      <= ad_i;
            pt_r      <= pt_i;
            ct_r      <= 384'd0;
            tag_r     <= 128'd0;
            ct_cnt_r  <= 2'd0;
            timeout_r <= 1'b0;
            extra_r   <= 1'b0;
        end else begin
            if ((state_r != IDLE) && cipher_valid_i) begin
                if (ct_cnt_r < 2'(NB_PT)) begin
                    ct_r[ct_cnt_r] <= cipher_i;
                    ct_cnt_r       <= ct_cnt_r + 2'd1;
                end else begin
                    extra_r <= 1'b1;
                end
            end
            if ((state_r == WAIT_END) && end_i) begin
                tag_r <= tag_i;
            end
            if (next_state_s == ERROR) begin
                timeout_r <= 1'b1;
            end
        end
    end

    assign start_o      = start_r;
    assign data_valid_o = dv_r;
    assign data_o       = data_r;
    assign busy_o       = busy_r;
    assign done_o       = done_r;
    assign key_o        = key_r;
    assign nonce_o      = nonce_r;
    assign ct_o         = ct_r;
    assign tag_o        = tag_r;
    assign timeout_o    = timeout_r;
    assign extra_ct_o   = extra_r;

endmodule
